// File: rtl/display_scanner.sv
// Time-multiplexed 7-segment scanner: double-buffered BCD frame, LSD-first digit
// slots with a leading blanking gap, BCD decode and optional leading-zero blanking.
module display_scanner #(
    parameter int DIGITS       = 3,
    parameter int SCAN_DIV     = 4000,
    parameter int BLANK_CYCLES = 400
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  zero_suppress,
    output logic                  pending,
    output logic                  frame_start,
    output logic                  blank,
    output logic [6:0]            segments,
    output logic [DIGITS-1:0]     enable
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] P_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);
    localparam logic [IW-1:0] I_LAST  = IW'(DIGITS - 1);

    typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         p_q, p_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   shadow_q, shadow_d;
    logic [4*DIGITS-1:0]   active_q, active_d;
    logic                  pending_q, pending_d;
    logic                  frame_start_q, frame_start_d;
    logic                  blank_q, blank_d;
    logic [6:0]            segments_q, segments_d;
    logic [DIGITS-1:0]     enable_q, enable_d;

    logic                  wrap;
    logic                  boundary;
    logic [3:0]            cur_digit;
    logic                  cur_suppress;
    logic                  all_zero;
    logic [DIGITS-1:0]     lead_zero;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    always_comb begin
        wrap     = (p_q == P_LAST);
        boundary = wrap && (idx_q == I_LAST);

        p_d   = wrap ? '0 : p_q + 1'b1;
        idx_d = idx_q;
        if (wrap) begin
            idx_d = (idx_q == I_LAST) ? '0 : idx_q + 1'b1;
        end

        // state_q always tracks p_q: BLANK for p < BLANK_CYCLES, DRIVE after
        state_d = state_q;
        if (wrap) begin
            state_d = ST_BLANK;
        end else if (p_d == P_BLANK) begin
            state_d = ST_DRIVE;
        end

        // A digit above 0 is a leading zero when it and every higher digit are 0
        all_zero  = 1'b1;
        lead_zero = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero     = all_zero && (active_q[4*i +: 4] == 4'd0);
            lead_zero[i] = all_zero && (i != 0);
        end

        cur_digit    = 4'd0;
        cur_suppress = 1'b0;
        enable_d     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_digit    = active_q[4*i +: 4];
                cur_suppress = lead_zero[i];
                enable_d[i]  = (state_q == ST_DRIVE);
            end
        end

        if (state_q == ST_DRIVE) begin
            segments_d = (zero_suppress && cur_suppress) ? 7'h00 : seg_decode(cur_digit);
            blank_d    = 1'b0;
        end else begin
            segments_d = 7'h00;
            blank_d    = 1'b1;
        end

        frame_start_d = boundary;

        // Boundary transfer reads the pre-load shadow; a coincident load re-arms pending
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (boundary && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (load) begin
            shadow_d  = bcd_in;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_BLANK;
            p_q           <= '0;
            idx_q         <= '0;
            shadow_q      <= '0;
            active_q      <= '0;
            pending_q     <= 1'b0;
            frame_start_q <= 1'b0;
            blank_q       <= 1'b1;
            segments_q    <= 7'h00;
            enable_q      <= '0;
        end else begin
            state_q       <= state_d;
            p_q           <= p_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            pending_q     <= pending_d;
            frame_start_q <= frame_start_d;
            blank_q       <= blank_d;
            segments_q    <= segments_d;
            enable_q      <= enable_d;
        end
    end

    assign pending     = pending_q;
    assign frame_start = frame_start_q;
    assign blank       = blank_q;
    assign segments    = segments_q;
    assign enable      = enable_q;

endmodule
